// File: rtl/morus_tx_sched_pkg.sv
// morus_tx_sched_pkg: symbol codes, unit counts and FSM states shared by the Morse scheduler
package morus_tx_sched_pkg;
  typedef enum logic [1:0] {SYM_DOT = 2'b00, SYM_DASH = 2'b01, SYM_CGAP = 2'b10, SYM_WGAP = 2'b11} sym_t;
  typedef enum logic [2:0] {IDLE, MARK, SPACE, GAP, KEY, HOLD} state_t;
  localparam int UNITS_DOT = 1;
  localparam int UNITS_DASH = 3;
  localparam int UNITS_SPACE = 1;
  localparam int UNITS_CGAP = 2;
  localparam int UNITS_WGAP = 6;
  function automatic int sym_units(input sym_t s);
    return s == SYM_DOT ? UNITS_DOT : s == SYM_DASH ? UNITS_DASH : s == SYM_CGAP ? UNITS_CGAP : UNITS_WGAP;
  endfunction
  function automatic logic sym_is_mark(input sym_t s);
    return s == SYM_DOT || s == SYM_DASH;
  endfunction
endpackage

// File: rtl/morus_tx_sched_fifo.sv
// morus_sym_fifo: first-word-fall-through symbol FIFO with full/empty flags
module morus_sym_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [1:0] din,
  input  logic       pop,
  output logic [1:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/morus_tx_sched.sv
// morus_tx_sched: times queued Morse symbols onto the line, yielding to the local key when idle
module morus_tx_sched
  import morus_tx_sched_pkg::*;
#(
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_UNITS = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SYM_VALID,
  input  logic [1:0] SYM,
  output logic       SYM_READY,
  input  logic       KEY_IN,
  output logic       MORUS_OUT,
  output logic       MORUS_LED,
  output logic       BUSY,
  output logic       OWNER_KEY
);
  localparam int TW = $clog2(6 * UNIT_CYCLES);
  state_t state;
  logic [TW-1:0] timer;
  logic [1:0] head;
  logic full, empty, pop;
  sym_t head_sym;
  function automatic logic [TW-1:0] load(input int units);
    return TW'(units * UNIT_CYCLES - 1);
  endfunction
  assign head_sym = sym_t'(head);
  assign pop = state == IDLE && !KEY_IN && !empty;
  assign SYM_READY = !full;
  assign MORUS_OUT = state == MARK || state == KEY;
  assign MORUS_LED = MORUS_OUT;
  assign BUSY = state != IDLE || !empty;
  assign OWNER_KEY = state == KEY || state == HOLD;
  morus_sym_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(CLK), .rst(RST), .push(SYM_VALID && SYM_READY), .din(SYM),
    .pop(pop), .dout(head), .full(full), .empty(empty)
  );
  // Timer holds at 0 on expiry; every state leaves on the expiry cycle so it never wraps
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      case (state)
        IDLE:
          if (KEY_IN) state <= KEY;
          else if (!empty) begin
            state <= sym_is_mark(head_sym) ? MARK : GAP;
            timer <= load(sym_units(head_sym));
          end
        MARK:
          if (timer == '0) begin
            state <= SPACE;
            timer <= load(UNITS_SPACE);
          end else timer <= timer - 1'b1;
        SPACE, GAP:
          if (timer == '0) state <= IDLE;
          else timer <= timer - 1'b1;
        KEY:
          if (!KEY_IN) begin
            state <= HOLD;
            timer <= load(HOLD_UNITS);
          end
        HOLD:
          if (KEY_IN) state <= KEY;
          else if (timer == '0) state <= IDLE;
          else timer <= timer - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_morus_tx_sched.sv
// tb_morus_tx_sched: randomized scoreboard bench comparing line segment lengths with a symbol-level model
module tb_morus_tx_sched;
  localparam int U = 4;
  localparam int DEPTH = 4;
  localparam int HOLD = 3;
  localparam logic [1:0] DOT = 2'b00, DASH = 2'b01, CGAP = 2'b10, WGAP = 2'b11;
  logic CLK = 0, RST = 1, SYM_VALID = 0, KEY_IN = 0;
  logic [1:0] SYM = 0;
  logic SYM_READY, MORUS_OUT, MORUS_LED, BUSY, OWNER_KEY;
  int n_chk = 0, n_fail = 0, cyc = 0, accept_cyc = 0, rel_cyc = 0;
  typedef struct {bit lvl; int len;} seg_t;
  seg_t exp_q[$];
  bit have_mark = 0, prev = 0, seen_high = 0, t6_on = 0, owner_seen = 0;
  int pend = 0, run = 0;

  morus_tx_sched #(.UNIT_CYCLES(U), .FIFO_DEPTH(DEPTH), .HOLD_UNITS(HOLD)) dut (
    .CLK(CLK), .RST(RST), .SYM_VALID(SYM_VALID), .SYM(SYM), .SYM_READY(SYM_READY),
    .KEY_IN(KEY_IN), .MORUS_OUT(MORUS_OUT), .MORUS_LED(MORUS_LED), .BUSY(BUSY), .OWNER_KEY(OWNER_KEY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(string name, int got, int want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endfunction

  function automatic int units(logic [1:0] s);
    return s == DOT ? 1 : s == DASH ? 3 : s == CGAP ? 2 : 6;
  endfunction

  // A mark is 'units' of high followed by one unit of space and an idle cycle; gaps extend that low run
  function automatic void model_push(logic [1:0] s);
    if (s == DOT || s == DASH) begin
      if (have_mark) exp_q.push_back('{1'b0, pend});
      exp_q.push_back('{1'b1, units(s) * U});
      pend = U + 1;
      have_mark = 1;
    end else if (have_mark) pend += units(s) * U + 1;
  endfunction

  function automatic void sb(bit lvl, int len);
    seg_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_unexpected: got level %0d length %0d, expected no segment", lvl, len);
      return;
    end
    e = exp_q.pop_front();
    chk(lvl ? "sb_mark_len" : "sb_space_len", len, e.len);
    chk("sb_level", lvl, e.lvl);
  endfunction

  always @(negedge CLK) begin
    if (t6_on && OWNER_KEY) owner_seen = 1;
    if (RST || OWNER_KEY) begin
      prev = 0;
      run = 0;
      seen_high = 0;
    end else begin
      if (!BUSY) seen_high = 0;
      if (MORUS_OUT !== prev) begin
        if (prev) begin
          sb(1, run);
          seen_high = 1;
        end else if (seen_high) sb(0, run);
        run = 1;
        prev = MORUS_OUT;
      end else run++;
    end
    chk("led_copy", MORUS_LED, MORUS_OUT);
  end

  task automatic push(input logic [1:0] s);
    int n = 0;
    SYM = s;
    SYM_VALID = 1;
    @(negedge CLK);
    while (!SYM_READY && n < 2000) begin
      n++;
      @(negedge CLK);
    end
    if (!SYM_READY) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_timeout: ready 0 after %0d cycles, required 1", n);
    end else begin
      @(posedge CLK);
      #1;
      accept_cyc = cyc;
      model_push(s);
    end
    SYM_VALID = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (BUSY && n < 5000);
    if (BUSY) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: busy 1 after %0d cycles, required 0", n);
    end
    @(posedge CLK);
    #1;
    have_mark = 0;
  endtask

  task automatic wait_high();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!MORUS_OUT && n < 200);
    if (!MORUS_OUT) begin
      n_chk++;
      n_fail++;
      $display("FAIL high_timeout: line 0 after %0d cycles, required 1", n);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int n, b;
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    @(negedge CLK);
    chk("t1_out", MORUS_OUT, 0);
    chk("t1_led", MORUS_LED, 0);
    chk("t1_busy", BUSY, 0);
    chk("t1_owner", OWNER_KEY, 0);
    chk("t1_ready", SYM_READY, 1);
    @(posedge CLK);
    #1;
    push(DOT);
    push(DASH);
    push(DOT);
    wait_high();
    RST = 1;
    exp_q.delete();
    have_mark = 0;
    @(negedge CLK);
    chk("t1_mid_out", MORUS_OUT, 0);
    chk("t1_mid_busy", BUSY, 0);
    chk("t1_mid_owner", OWNER_KEY, 0);
    chk("t1_mid_ready", SYM_READY, 1);
    @(posedge CLK);
    #1 RST = 0;
    repeat (3) @(negedge CLK);
    chk("t1_fifo_lost_busy", BUSY, 0);
    chk("t1_fifo_lost_out", MORUS_OUT, 0);
    @(posedge CLK);
    #1;

    push(DOT);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!MORUS_OUT && n < 50);
    chk("t2_latency", n, 2);
    b = 0;
    while (BUSY && b < 100) begin
      b++;
      @(negedge CLK);
    end
    chk("t2_busy_cycles", b, 2 * U);
    wait_idle();

    push(DASH);
    push(CGAP);
    push(DOT);
    wait_idle();

    KEY_IN = 1;
    @(negedge CLK);
    @(posedge CLK);
    #1;
    for (int i = 0; i < DEPTH; i++) push(DOT);
    @(negedge CLK);
    chk("t4_full_ready", SYM_READY, 0);
    chk("t4_owner", OWNER_KEY, 1);
    chk("t4_key_out", MORUS_OUT, 1);
    chk("t4_busy", BUSY, 1);
    @(posedge CLK);
    #1;
    fork
      push(DOT);
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge CLK);
          chk("t4_stall_ready", SYM_READY, 0);
        end
        @(posedge CLK);
        #1 KEY_IN = 0;
        rel_cyc = cyc;
      end
    join
    chk("t4_accept_delay", accept_cyc - rel_cyc, HOLD * U + 3);
    wait_idle();

    push(DASH);
    KEY_IN = 1;
    @(negedge CLK);
    @(negedge CLK);
    chk("t5_owner", OWNER_KEY, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t5_key_mark", MORUS_OUT, 1);
      @(negedge CLK);
    end
    @(posedge CLK);
    #1 KEY_IN = 0;
    @(negedge CLK);
    @(negedge CLK);
    chk("t5_hold_out", MORUS_OUT, 0);
    chk("t5_hold_owner", OWNER_KEY, 1);
    @(posedge CLK);
    #1 KEY_IN = 1;
    @(negedge CLK);
    @(negedge CLK);
    chk("t5_rekey_out", MORUS_OUT, 1);
    chk("t5_rekey_owner", OWNER_KEY, 1);
    @(posedge CLK);
    #1 KEY_IN = 0;
    @(negedge CLK);
    n = 0;
    do begin
      @(negedge CLK);
      if (!MORUS_OUT) n++;
    end while (!MORUS_OUT && n < 200);
    chk("t5_silent", n, HOLD * U + 1);
    wait_idle();

    t6_on = 1;
    owner_seen = 0;
    fork
      begin
        push(DASH);
        push(CGAP);
        push(DOT);
      end
      begin
        wait_high();
        repeat (3) @(posedge CLK);
        #1 KEY_IN = 1;
        repeat (3) @(posedge CLK);
        #1 KEY_IN = 0;
      end
    join
    wait_idle();
    t6_on = 0;
    chk("t6_owner_never", owner_seen, 0);

    for (int r = 0; r < 6; r++) begin
      int cnt = $urandom_range(3, 7);
      for (int k = 0; k < cnt; k++) push(2'($urandom_range(0, 3)));
      wait_idle();
    end

    repeat (3) @(negedge CLK);
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
